embed_combine: RTL and testbench
================================

EMBED_COMBINE -- requirements
Module: embed_combine

Interface
REQ-001 SHALL have parameter N_POS, default 8: positions per sequence and the depth of the position-embedding table.
REQ-002 SHALL have parameter N_EMBD, default 4: embedding lanes, each an 8-bit two's-complement value.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the token-embedding vector is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-007 SHALL have port in_vec, input, N_EMBD x 8 bits: the token-embedding lanes.
REQ-008 SHALL have port in_last, input, 1 bit: the token is the last one of its sequence.
REQ-009 SHALL have port pos_out, output, $clog2(N_POS) bits: address driven to the position-embedding table.
REQ-010 SHALL have port pos_emb, input, N_EMBD x 8 bits: table data, valid one clk after pos_out is applied.
REQ-011 SHALL have port out_valid, output, 1 bit: the combined vector is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the output.
REQ-013 SHALL have port out_vec, output, N_EMBD x 8 bits: lane-wise sum of in_vec and pos_emb.
REQ-014 SHALL have port out_pos, output, $clog2(N_POS) bits: position of the token in out_vec.
REQ-015 SHALL have port out_last, output, 1 bit: in_last carried with the token.
REQ-016 SHALL have port seq_err, output, 1 bit: sticky flag, set when a sequence exceeds N_POS tokens.

Function
REQ-017 SHALL accept an input when in_valid and in_ready are both 1, and SHALL otherwise ignore in_vec and in_last.
REQ-018 SHALL implement a two-entry pipeline: stage S1 holds the token vector, pos and last while awaiting pos_emb; stage OUT is the output register.
REQ-019 SHALL drive pos_out = S1.pos while S1 is full and not advancing, and pos_out = pos_cnt otherwise.
REQ-020 SHALL advance S1 into OUT when S1 is full and (OUT is empty or out_ready=1).
REQ-021 SHALL drive in_ready = 1 when S1 is empty or S1 advances this cycle; in_ready SHALL depend combinationally on out_ready, with no dependence on in_valid.
REQ-022 SHALL produce out_valid two clk edges after acceptance when no stall occurs, and SHALL sustain one token per cycle when out_ready=1.
REQ-023 SHALL compute out_vec[i] = in_vec[i] + pos_emb[i] as signed 8-bit values, using pos_emb sampled on the cycle S1 advances.
REQ-024 SHALL hold out_valid, out_vec, out_pos and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear OUT when out_valid=1 and out_ready=1 with S1 empty, and SHALL reload OUT in the same cycle when S1 advances.
REQ-026 SHALL increment pos_cnt on each accept, and SHALL set pos_cnt to 0 after accepting a token with in_last=1.
REQ-027 SHALL, on an accept with pos_cnt = N_POS-1 and in_last=0, wrap pos_cnt to 0 and set seq_err=1.
REQ-028 SHALL keep seq_err set until reset.

Reset
REQ-029 SHALL, with rst_n=0, asynchronously force pos_cnt=0, S1 and OUT empty, out_valid=0, out_vec=0, out_pos=0, out_last=0 and seq_err=0.
REQ-030 SHALL drive in_ready=1 and pos_out=0 during reset, and SHALL discard any in-flight token; no partial output SHALL appear after reset is released.
REQ-031 SHALL accept an input on the first clk edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with macro EMBED_COMBINE_SAT_EN defined, saturate each lane sum to the range -128..+127.
REQ-033 SHALL, with EMBED_COMBINE_SAT_EN undefined, wrap each lane sum modulo 256, with no other functional difference.

Verification
REQ-034 Stream 3 tokens, each in_vec={1,2,3,4}, pos_emb table row p = {p,p,p,p}, out_ready=1 -> out_vec {1,2,3,4}, {2,3,4,5}, {3,4,5,6}; out_pos 0,1,2; first out_valid 2 cycles after the first accept.
REQ-035 Hold out_ready=0 for 5 cycles with 4 tokens offered -> in_ready falls after 2 accepts; out_vec and pos_out stay stable; after release all 4 tokens emerge in order with no loss or duplication.
REQ-036 Lane in_vec=100 with pos_emb=100 -> out_vec 127 with EMBED_COMBINE_SAT_EN defined, -56 without; in_vec=-100 with pos_emb=-100 -> -128 with the macro, 56 without.
REQ-037 Send in_last=1 on the 3rd token, then 2 more tokens -> out_pos 0,1,2,0,1; the 3rd output has out_last=1; seq_err stays 0.
REQ-038 Send 9 tokens with N_POS=8 and no in_last -> the 9th token has out_pos 0 and seq_err=1, and seq_err holds at 1 afterwards.
REQ-039 Assert rst_n=0 for one cycle with both stages full -> out_valid=0 and seq_err=0 immediately; the next accept gets out_pos 0.

Source files
------------

// File: rtl/embed_combine.sv
// embed_combine: adds a position-embedding row to each token vector through a two-stage elastic pipeline.
// Define EMBED_COMBINE_SAT_EN to saturate lane sums instead of wrapping them.
module embed_combine #(
  parameter int N_POS = 8,
  parameter int N_EMBD = 4,
  localparam int PW = N_POS > 1 ? $clog2(N_POS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_EMBD-1:0][7:0] in_vec,
  input  logic                   in_last,
  output logic [PW-1:0]          pos_out,
  input  logic [N_EMBD-1:0][7:0] pos_emb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_EMBD-1:0][7:0] out_vec,
  output logic [PW-1:0]          out_pos,
  output logic                   out_last,
  output logic                   seq_err
);
  logic                   s1_full, s1_last, advance, accept, at_end;
  logic [N_EMBD-1:0][7:0] s1_vec, sum;
  logic [PW-1:0]          s1_pos, pos_cnt;
  assign advance  = s1_full && (!out_valid || out_ready);
  assign in_ready = !s1_full || advance;
  assign accept   = in_valid && in_ready;
  assign at_end   = pos_cnt == PW'(N_POS - 1);
  // A stalled S1 keeps re-reading its own row so pos_emb stays valid for it
  assign pos_out  = (s1_full && !advance) ? s1_pos : pos_cnt;
  for (genvar i = 0; i < N_EMBD; i++) begin : g_lane
`ifdef EMBED_COMBINE_SAT_EN
    logic [8:0] w;
    assign w = {s1_vec[i][7], s1_vec[i]} + {pos_emb[i][7], pos_emb[i]};
    assign sum[i] = (w[8] != w[7]) ? {w[8], {7{~w[8]}}} : w[7:0];
`else
    assign sum[i] = s1_vec[i] + pos_emb[i];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full   <= 1'b0;
      s1_vec    <= '0;
      s1_pos    <= '0;
      s1_last   <= 1'b0;
      pos_cnt   <= '0;
      seq_err   <= 1'b0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_pos   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        s1_vec  <= in_vec;
        s1_pos  <= pos_cnt;
        s1_last <= in_last;
        pos_cnt <= (in_last || at_end) ? '0 : pos_cnt + PW'(1);
        if (at_end && !in_last) seq_err <= 1'b1;
      end
      s1_full <= accept || (s1_full && !advance);
      if (advance) begin
        out_valid <= 1'b1;
        out_vec   <= sum;
        out_pos   <= s1_pos;
        out_last  <= s1_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_embed_combine.sv
// tb_embed_combine: randomized scoreboard bench for embed_combine against a token-level reference model.
module tb_embed_combine;
  localparam int N_POS = 8;
  localparam int N_EMBD = 4;
  typedef logic [N_EMBD-1:0][7:0] vec_t;
  typedef struct {vec_t vec; int pos; logic last;} tok_t;
  logic clk = 0, rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_last, seq_err;
  vec_t in_vec, pos_emb, out_vec, h_vec;
  logic [2:0] pos_out, out_pos, h_pos;
  logic h_last, hold;
  vec_t tbl [N_POS];
  tok_t q[$];
  int total = 0, bad = 0, m_cnt = 0;
  logic m_err = 0;
  embed_combine #(.N_POS(N_POS), .N_EMBD(N_EMBD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_last(in_last), .pos_out(pos_out), .pos_emb(pos_emb), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .out_pos(out_pos), .out_last(out_last),
    .seq_err(seq_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) pos_emb <= tbl[pos_out];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] lane_sum(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef EMBED_COMBINE_SAT_EN
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction
  always @(posedge clk) begin
    tok_t t;
    if (rst_n && in_valid && in_ready) begin
      for (int i = 0; i < N_EMBD; i++) t.vec[i] = lane_sum(in_vec[i], tbl[m_cnt][i]);
      t.pos = m_cnt;
      t.last = in_last;
      q.push_back(t);
      if (!in_last && m_cnt == N_POS - 1) m_err = 1;
      m_cnt = (in_last || m_cnt == N_POS - 1) ? 0 : m_cnt + 1;
    end
  end
  always @(posedge clk) begin
    tok_t t;
    if (!rst_n) hold = 0;
    else begin
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_vec", out_vec, h_vec);
        check("hold_pos", 32'(out_pos), 32'(h_pos));
        check("hold_last", 32'(out_last), 32'(h_last));
      end
      hold = out_valid && !out_ready;
      h_vec = out_vec;
      h_pos = out_pos;
      h_last = out_last;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%0h required=none", out_vec);
        end else begin
          t = q.pop_front();
          check("out_vec", out_vec, t.vec);
          check("out_pos", 32'(out_pos), 32'(t.pos));
          check("out_last", 32'(out_last), 32'(t.last));
        end
      end
    end
  end
  always @(negedge clk) if (rst_n) check("seq_err", 32'(seq_err), 32'(m_err));
  task automatic send(input vec_t v, input logic l);
    int n = 0;
    in_vec = v;
    in_last = l;
    in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", q.size(), 0);
  endtask
  task automatic reset_dut();
    rst_n = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pos_out", 32'(pos_out), 32'd0);
    q.delete();
    m_cnt = 0;
    m_err = 0;
    hold = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    int acc;
    rst_n = 0; in_valid = 0; in_vec = '0; in_last = 0; out_ready = 1;
    for (int p = 0; p < N_POS; p++) tbl[p] = {N_EMBD{8'(p)}};
    tbl[0][0] = 8'd100;
    tbl[0][1] = 8'h9c;
    repeat (2) @(negedge clk);
    reset_dut();
    // lane 0: 100+100, lane 1: -100+-100
    send({8'd5, 8'd7, 8'h9c, 8'd100}, 1);
    acc = 0;
    while (!out_valid && acc < 10) begin
      @(negedge clk);
      acc++;
    end
`ifdef EMBED_COMBINE_SAT_EN
    check("sat_pos", 32'(out_vec[0]), 32'h7f);
    check("sat_neg", 32'(out_vec[1]), 32'h80);
`else
    check("wrap_pos", 32'(out_vec[0]), 32'hc8);
    check("wrap_neg", 32'(out_vec[1]), 32'h38);
`endif
    drain();
    tbl[0] = '0;
    @(negedge clk);
    in_vec = {8'd4, 8'd3, 8'd2, 8'd1};
    in_last = 0;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    check("latency_1edge", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_2edge", 32'(out_valid), 32'd1);
    check("first_vec", out_vec, {8'd4, 8'd3, 8'd2, 8'd1});
    send({8'd4, 8'd3, 8'd2, 8'd1}, 0);
    send({8'd4, 8'd3, 8'd2, 8'd1}, 0);
    drain();
    reset_dut();
    for (int k = 0; k < 5; k++) send(vec_t'($urandom), k == 2);
    drain();
    reset_dut();
    out_ready = 0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1;
      in_last = 0;
      in_vec = vec_t'($urandom);
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 0;
    check("stall_accepts", acc, 2);
    out_ready = 1;
    send(vec_t'($urandom), 0);
    send(vec_t'($urandom), 0);
    drain();
    reset_dut();
    for (int k = 0; k < 9; k++) send(vec_t'($urandom), 0);
    drain();
    check("seq_err_set", 32'(seq_err), 32'd1);
    repeat (3) @(negedge clk);
    check("seq_err_hold", 32'(seq_err), 32'd1);
    out_ready = 0;
    send(vec_t'($urandom), 0);
    send(vec_t'($urandom), 0);
    check("full_before_rst", 32'(out_valid), 32'd1);
    reset_dut();
    out_ready = 1;
    send(vec_t'($urandom), 0);
    drain();
    for (int p = 0; p < N_POS; p++) tbl[p] = vec_t'($urandom);
    @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_vec = vec_t'($urandom);
      in_last = $urandom_range(0, 9) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
